// File: rtl/output_port_arbiter.sv
// Output port arbiter for a router.
// Several input port controllers compete for one output port. A single winner
// is chosen round-robin and keeps the port for a whole packet. The first BUSY
// cycle is a hand-off cycle, followed by flit_number flit cycles. Every
// requester that does not hold the grant is stalled.
module output_port_arbiter #(
  parameter int port_number = 5,
  parameter int index_width = 3,
  parameter int flit_size   = 4,
  parameter int packet_size = 32,
  parameter int count_width = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [port_number-1:0] request,
  output logic [port_number-1:0] stall,
  output logic [port_number-1:0] grant,
  output logic [index_width-1:0] mux_select,
  output logic                   link_valid,
  output logic                   busy
);

  localparam int flit_number = packet_size / flit_size;
  localparam logic [count_width-1:0] last_count = count_width'(flit_number);
  localparam logic [index_width-1:0] last_index = index_width'(port_number - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t                   state;
  logic [count_width-1:0]   counter;
  logic [index_width-1:0]   rr_pointer;

  logic                     found;
  logic [index_width-1:0]   winner;
  logic [port_number-1:0]   one_hot;
  int                       pos;

  // Round-robin search: the first set request bit at or above rr_pointer, wrapping.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave it
    // unassigned and infer a latch.
    found  = 1'b0;
    winner = '0;
    pos    = 0;
    for (int i = 0; i < port_number; i++) begin
      pos = int'(rr_pointer) + i;
      if (pos >= port_number) pos = pos - port_number;
      if (!found && request[pos]) begin
        found  = 1'b1;
        winner = index_width'(pos);
      end
    end
  end

  // Grant vector for the current winner.
  assign one_hot = port_number'(1) << winner;

  // Arbitration FSM. Grant, select, counter and pointer are all registered here.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge, whatever the statement order.
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      mux_select <= '0;
      counter    <= '0;
      rr_pointer <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant      <= one_hot;
            mux_select <= winner;
            rr_pointer <= (winner == last_index) ? '0 : winner + 1'b1;
            counter    <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          // The grant is held for the whole packet. The winner's request is ignored here.
          if (counter == last_count) begin
            grant   <= '0;
            counter <= '0;
            state   <= IDLE;
          end else begin
            counter <= counter + 1'b1;
          end
        end
      endcase
    end
  end

  // Link valid during the flit cycles 1..flit_number of a packet.
  assign link_valid = (state == BUSY) && (counter >= count_width'(1)) && (counter <= last_count);
  assign busy       = (state == BUSY);

  // Any requester that does not hold the grant must wait.
  assign stall = request & ~grant;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter.
// A transaction-level model tracks which input owns the port, how long it has
// owned it, and where the next round-robin search starts. Outputs are compared
// every cycle under directed and random request patterns.
module tb_output_port_arbiter;

  localparam int N     = 5;
  localparam int FLITS = 8;

  logic         clk;
  logic         reset;
  logic [N-1:0] request;
  logic [N-1:0] stall;
  logic [N-1:0] grant;
  logic [2:0]   mux_select;
  logic         link_valid;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  // Model state: owner is -1 when no packet holds the port.
  int m_owner = -1;
  int m_age   = 0;
  int m_next  = 0;
  int m_sel   = 0;

  output_port_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .request    (request),
    .stall      (stall),
    .grant      (grant),
    .mux_select (mux_select),
    .link_valid (link_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge(input logic rst, input logic [N-1:0] req);
    if (rst) begin
      m_owner = -1;
      m_age   = 0;
      m_next  = 0;
      m_sel   = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int cand = (m_next + k) % N;
        if (m_owner < 0 && req[cand]) begin
          m_owner = cand;
        end
      end
      if (m_owner >= 0) begin
        m_age  = 0;
        m_sel  = m_owner;
        m_next = (m_owner + 1) % N;
      end
    end else if (m_age == FLITS) begin
      m_owner = -1;
      m_age   = 0;
    end else begin
      m_age++;
    end
  endtask

  // Drive one cycle, check the outputs mid-cycle, then let the edge happen.
  task automatic step(input logic rst, input logic [N-1:0] req);
    logic [N-1:0] e_grant;
    @(negedge clk);
    reset   = rst;
    request = req;
    #1;
    e_grant = (m_owner >= 0) ? N'(1) << m_owner : '0;
    check("grant",      32'(grant),      32'(e_grant));
    check("mux_select", 32'(mux_select), 32'(m_sel));
    check("busy",       32'(busy),       32'(m_owner >= 0));
    check("link_valid", 32'(link_valid), 32'(m_owner >= 0 && m_age >= 1 && m_age <= FLITS));
    check("stall",      32'(stall),      32'(req & ~e_grant));
    @(posedge clk);
    model_edge(rst, req);
  endtask

  task automatic run(input logic rst, input logic [N-1:0] req, input int n);
    for (int k = 0; k < n; k++) step(rst, req);
  endtask

  initial begin
    reset   = 1'b1;
    request = '0;
    repeat (2) @(posedge clk);
    model_edge(1'b1, '0);

    // Single requester holding its request.
    run(1'b1, 5'b00000, 1);
    run(1'b0, 5'b00100, 12);

    // Three requesters rotate 0, 1, 4, 0.
    run(1'b1, 5'b00000, 1);
    run(1'b0, 5'b10011, 42);

    // Input 1 joins at BUSY counter 4 while input 3 owns the port.
    run(1'b1, 5'b00000, 1);
    run(1'b0, 5'b01000, 5);
    run(1'b0, 5'b01010, 12);
    run(1'b0, 5'b00010, 10);

    // The winner drops its request after BUSY cycle 0. The grant is held.
    run(1'b1, 5'b00000, 1);
    run(1'b0, 5'b00100, 2);
    run(1'b0, 5'b00000, 12);

    // Reset at BUSY counter 5. The pointer returns to 0.
    run(1'b1, 5'b00000, 1);
    run(1'b0, 5'b10000, 7);
    run(1'b1, 5'b10000, 1);
    run(1'b0, 5'b00011, 12);

    // Long quiet period.
    run(1'b1, 5'b00000, 1);
    run(1'b0, 5'b00000, 20);

    // Random traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] r;
      logic         rs;
      r  = N'($urandom) & N'($urandom);
      rs = ($urandom_range(0, 59) == 0);
      step(rs, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
- Shares one router output port among `port_number` input port controllers.
- Collects their routed requests, picks one winner with round-robin priority, and holds the grant for a full packet.
- Drives per-input `stall` back to the port controllers.
- Drives the crossbar select and output-link valid for the granted input.

Parameters:
- `port_number`, 5, number of input port controllers sharing this output.
- `index_width`, 3, width of the crossbar select; must satisfy 2^index_width >= port_number.
- `flit_size`, 4, bits per flit; informational, sets no logic widths.
- `packet_size`, 32, bits per packet; flit_number = packet_size/flit_size = 8.
- `count_width`, 4, width of the flit counter; must hold values 0..flit_number.

Ports:
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high reset.
- `request`  input  port_number  bit i high while input i holds a routed packet for this output (its current_address_ready, qualified by destination).
- `stall`  output  port_number  per-input hold-off; input i must not transmit while stall[i]=1.
- `grant`  output  port_number  one-hot registered grant; all zero when idle.
- `mux_select`  output  index_width  binary index of the granted input, for the crossbar.
- `link_valid`  output  1  high in cycles where the granted input's flit is on the output link.
- `busy`  output  1  high while a packet owns the port.

Behaviour:
- Reset is synchronous on posedge `clk` with `reset`=1. Reset values:
  - state=IDLE, grant=0, mux_select=0, counter=0, rr_pointer=0.
  - busy=0, link_valid=0.
  - stall = request (combinational, since grant=0).
- `stall` is combinational from registered grant: stall[i] = request[i] & ~grant[i]. All other outputs are registered or decoded from registered state.
- IDLE:
  - If request==0, stay in IDLE.
  - Otherwise, pick the winner: the first set request bit scanning upward from rr_pointer, wrapping modulo port_number.
  - At the clock edge: grant <= onehot(winner), mux_select <= winner, rr_pointer <= (winner+1) mod port_number, counter <= 0, state <= BUSY.
  - Every requester sees stall=1 during the IDLE decision cycle.
- BUSY:
  - counter increments every cycle.
  - The winner sees stall=0 in BUSY cycle 0 and begins sending one flit per cycle from cycle 1.
  - link_valid = 1 when counter in 1..flit_number (exactly flit_number cycles).
  - At counter==flit_number: grant <= 0, counter <= 0, state <= IDLE.
  - A packet occupies flit_number+1 BUSY cycles.
- Grant is held through BUSY regardless of the winner's request. The winner drops request once it starts sending; no early release.
- New or continuing requests during BUSY see stall=1 and wait.
- After each packet there is at least one IDLE cycle before the next grant. A back-to-back packet is 1 IDLE + 9 BUSY cycles.
- Simultaneous requests: resolved strictly by rr_pointer. A requester loses at most port_number-1 consecutive arbitrations.
- request bits at index >= port_number do not exist. mux_select values >= port_number never occur.
- Reset mid-packet: immediate return to the reset values, including rr_pointer=0. The partially sent packet is the sender's responsibility.
- Counter arithmetic is unsigned count_width bits; it never wraps because it is cleared at flit_number.

Test Plan:
1. Reset, then request=5'b00100 held → cycle 0 IDLE with stall=5'b00100; next cycle grant=5'b00100, mux_select=2, stall=0. link_valid high for exactly 8 cycles starting one cycle later. grant=0 after 9 BUSY cycles.
2. request=5'b10011 from reset → grants in order 0, 1, 4, then 0 again. Each grant lasts 9 cycles and has a 1-cycle IDLE gap.
3. Input 3 granted, then request[1] rises at BUSY counter=4 → stall[1]=1 until input 1 is granted one cycle after grant[3] clears. mux_select goes 3→1.
4. Winner 2 deasserts request at BUSY counter=1 → grant[2] stays high and link_valid stays high through counter=8. No other grant is issued.
5. reset asserted at BUSY counter=5 → next cycle grant=0, busy=0, link_valid=0, rr_pointer=0. A subsequent request=5'b00011 grants input 0.
6. request=0 for 20 cycles → state stays IDLE, grant=0, link_valid=0, stall=0.
